mem_stage: RTL and testbench

Memory-access stage directly upstream of the write-back stage in the single-cycle RISC-V core. It takes the EX-computed address, store data and load/store controls, and runs a req/ready handshake with a multi-cycle data memory. It stalls the core until the access completes. It returns aligned, sign- or zero-extended load data as data_mem_read_data for write-back selection.

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_load_align.sv | 18 +
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: RV32I funct3 size codes, memory-stage FSM states and default watchdog limit.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int WAIT_MAX_DEF = 255;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts the addressed lane down and sign/zero-extends it by funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lo,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_data
);
    logic [31:0] w_lane;
    always_comb begin
        w_lane = i_rdata >> {i_lo, 3'b000};
        o_data = i_f3 == F3_B  ? {{24{w_lane[7]}}, w_lane[7:0]} :
                 i_f3 == F3_H  ? {{16{w_lane[15]}}, w_lane[15:0]} :
                 i_f3 == F3_BU ? {24'b0, w_lane[7:0]} :
                 i_f3 == F3_HU ? {16'b0, w_lane[15:0]} : w_lane;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with req/ready handshake, stall and watchdog abort.
// Optional alignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_memread,
    input  logic              ID_memwrite,
    input  logic [2:0]        ID_funct3,
    input  logic [31:0]       EX_result,
    input  logic [31:0]       ID_rs2_data,
    output logic              data_mem_req,
    output logic              data_mem_we,
    output logic [ADDR_W-1:0] data_mem_addr,
    output logic [31:0]       data_mem_wdata,
    output logic [3:0]        data_mem_wstrb,
    input  logic [31:0]       data_mem_rdata,
    input  logic              data_mem_ready,
    output logic [31:0]       data_mem_read_data,
    output logic              mem_stall,
    output logic              mem_bus_err,
    output logic              mem_misalign
);
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lo;
    logic [2:0]  r_f3;
    logic        r_err;
    logic        w_acc, w_mis, w_expire;
    logic [31:0] w_wdata, w_load;
    logic [3:0]  w_wstrb;

    mem_load_align u_align (
        .i_rdata (data_mem_rdata),
        .i_lo    (r_lo),
        .i_f3    (r_f3),
        .o_data  (w_load)
    );

    always_comb begin
        w_acc    = ID_memread | ID_memwrite;
        w_expire = r_cnt == 8'(WAIT_MAX - 1);
        w_wdata  = ID_funct3[1:0] == F3_B[1:0] ? {4{ID_rs2_data[7:0]}} :
                   ID_funct3[1:0] == F3_H[1:0] ? {2{ID_rs2_data[15:0]}} : ID_rs2_data;
        w_wstrb  = ID_funct3[1:0] == F3_B[1:0] ? 4'b0001 << EX_result[1:0] :
                   ID_funct3[1:0] == F3_H[1:0] ? 4'b0011 << {EX_result[1], 1'b0} : 4'b1111;
        w_next   = r_state == IDLE ? (w_acc ? (w_mis ? DONE : REQ) : IDLE) :
                   r_state == REQ  ? ((data_mem_ready || w_expire) ? DONE : REQ) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_lo               <= '0;
            r_f3               <= '0;
            r_err              <= 1'b0;
            data_mem_we        <= 1'b0;
            data_mem_addr      <= '0;
            data_mem_wdata     <= '0;
            data_mem_wstrb     <= '0;
            data_mem_read_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_err <= 1'b0;
                r_cnt <= '0;
                if (w_acc && !w_mis) begin
                    data_mem_we    <= ID_memwrite;
                    data_mem_addr  <= {EX_result[ADDR_W-1:2], 2'b00};
                    data_mem_wdata <= w_wdata;
                    data_mem_wstrb <= w_wstrb;
                    r_lo           <= EX_result[1:0];
                    r_f3           <= ID_funct3;
                end
            end else if (r_state == REQ) begin
                r_cnt <= r_cnt + 8'd1;
                if (data_mem_ready) begin
                    if (!data_mem_we)
                        data_mem_read_data <= w_load;
                end else if (w_expire) begin
                    r_err              <= 1'b1;
                    data_mem_read_data <= '0;
                end
            end
        end
    end

    assign data_mem_req = r_state == REQ;
    assign mem_stall    = !rst && (r_state == REQ || (r_state == IDLE && w_acc));
    assign mem_bus_err  = r_state == DONE && r_err;

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_mis;
    assign w_mis = (ID_funct3[1:0] == F3_H[1:0] && EX_result[0]) ||
                   (ID_funct3[1:0] == F3_W[1:0] && |EX_result[1:0]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mis <= 1'b0;
        else
            r_mis <= r_state == IDLE && w_acc && w_mis;
    end
    assign mem_misalign = r_state == DONE && r_mis;
`else
    assign w_mis        = 1'b0;
    assign mem_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a small ready-delay memory model.
module tb_mem_stage;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] addr, wdata, rd;
        logic [3:0]  wstrb;
        logic        we, err;
        int          stalls, reqs;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        ID_memread = 0, ID_memwrite = 0;
    logic [2:0]  ID_funct3 = 0;
    logic [31:0] EX_result = 0, ID_rs2_data = 0, data_mem_rdata = 0;
    logic        data_mem_ready = 0;
    logic        data_mem_req, data_mem_we, mem_stall, mem_bus_err, mem_misalign;
    logic [31:0] data_mem_addr, data_mem_wdata, data_mem_read_data;
    logic [3:0]  data_mem_wstrb;
    int          n_chk = 0, n_err = 0;
    exp_t        q[$];

    mem_stage #(.ADDR_W(32), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ID_memread(ID_memread), .ID_memwrite(ID_memwrite), .ID_funct3(ID_funct3),
        .EX_result(EX_result), .ID_rs2_data(ID_rs2_data),
        .data_mem_req(data_mem_req), .data_mem_we(data_mem_we), .data_mem_addr(data_mem_addr),
        .data_mem_wdata(data_mem_wdata), .data_mem_wstrb(data_mem_wstrb),
        .data_mem_rdata(data_mem_rdata), .data_mem_ready(data_mem_ready),
        .data_mem_read_data(data_mem_read_data), .mem_stall(mem_stall),
        .mem_bus_err(mem_bus_err), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, wd, input logic [3:0] ws, input logic we,
                                input logic [31:0] rd, input logic err, input int stalls, reqs);
        exp_t e;
        e.addr = a; e.wdata = wd; e.wstrb = ws; e.we = we;
        e.rd = rd; e.err = err; e.stalls = stalls; e.reqs = reqs;
        return e;
    endfunction

    // entered at posedge+1 with the DUT idle; memory raises ready after wait_n REQ cycles
    task automatic access(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, d, rw,
                          input int wait_n, input exp_t e, input string tag);
        int   stalls = 0, reqs = 0;
        logic done = 0;
        exp_t o;
        q.push_back(e);
        ID_memread = rd; ID_memwrite = wr; ID_funct3 = f3;
        EX_result = a; ID_rs2_data = d; data_mem_rdata = rw; data_mem_ready = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #4;
            if (data_mem_req) begin
                reqs++;
                chk({tag, ".addr"}, data_mem_addr, q[0].addr);
                chk({tag, ".wdata"}, data_mem_wdata, q[0].wdata);
                if (reqs == 1) begin
                    chk({tag, ".wstrb"}, 32'(data_mem_wstrb), 32'(q[0].wstrb));
                    chk({tag, ".we"}, 32'(data_mem_we), 32'(q[0].we));
                end
                data_mem_ready = reqs > wait_n;
            end else
                data_mem_ready = 0;
            if (mem_stall)
                stalls++;
            else begin
                o = q.pop_front();
                chk({tag, ".read_data"}, data_mem_read_data, o.rd);
                chk({tag, ".bus_err"}, 32'(mem_bus_err), 32'(o.err));
                chk({tag, ".stalls"}, stalls, o.stalls);
                chk({tag, ".reqs"}, reqs, o.reqs);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk({tag, ".timeout"}, 0, 1);
        ID_memread = 0; ID_memwrite = 0; data_mem_ready = 0;
    endtask

    initial begin
        #1;
        chk("rst.req", 32'(data_mem_req), 0);
        chk("rst.we", 32'(data_mem_we), 0);
        chk("rst.addr", data_mem_addr, 0);
        chk("rst.wdata", data_mem_wdata, 0);
        chk("rst.wstrb", 32'(data_mem_wstrb), 0);
        chk("rst.read_data", data_mem_read_data, 0);
        chk("rst.stall", 32'(mem_stall), 0);
        chk("rst.bus_err", 32'(mem_bus_err), 0);
        chk("rst.misalign", 32'(mem_misalign), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        access(1, 0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, mk(32'h100, 0, 4'b1111, 0, 32'hDEADBEEF, 0, 2, 1), "lw");
        access(1, 0, F3_B,  32'h103, 0, 32'h80FF0000, 0, mk(32'h100, 0, 4'b1000, 0, 32'hFFFFFF80, 0, 2, 1), "lb");
        access(1, 0, F3_BU, 32'h103, 0, 32'h80FF0000, 0, mk(32'h100, 0, 4'b1000, 0, 32'h00000080, 0, 2, 1), "lbu");
        access(1, 0, F3_H,  32'h102, 0, 32'h80FF0000, 0, mk(32'h100, 0, 4'b1100, 0, 32'hFFFF80FF, 0, 2, 1), "lh");
        access(0, 1, F3_B,  32'h101, 32'h12345678, 32'hFFFFFFFF, 0,
               mk(32'h100, 32'h78787878, 4'b0010, 1, 32'hFFFF80FF, 0, 2, 1), "sb");
        access(0, 1, F3_H,  32'h102, 32'h12345678, 32'hFFFFFFFF, 0,
               mk(32'h100, 32'h56785678, 4'b1100, 1, 32'hFFFF80FF, 0, 2, 1), "sh");
        access(0, 1, F3_W,  32'h10C, 32'hCAFEF00D, 32'hFFFFFFFF, 1,
               mk(32'h10C, 32'hCAFEF00D, 4'b1111, 1, 32'hFFFF80FF, 0, 3, 2), "sw");
        access(1, 0, F3_HU, 32'h102, 0, 32'h80FF0000, 0, mk(32'h100, 0, 4'b1100, 0, 32'h000080FF, 0, 2, 1), "lhu");
        access(1, 0, F3_W,  32'h104, 0, 32'h13579BDF, 3, mk(32'h104, 0, 4'b1111, 0, 32'h13579BDF, 0, 5, 4), "lw_wait3");
        access(1, 1, F3_W,  32'h108, 32'hA5A5A5A5, 32'hFFFFFFFF, 0,
               mk(32'h108, 32'hA5A5A5A5, 4'b1111, 1, 32'h13579BDF, 0, 2, 1), "rdwr");
        access(0, 0, F3_W,  32'h200, 0, 32'hFFFFFFFF, 0, mk(0, 0, 0, 0, 32'h13579BDF, 0, 0, 0), "nomem");
        access(1, 0, F3_W,  32'h110, 0, 32'h55555555, 1000, mk(32'h110, 0, 4'b1111, 0, 32'h0, 1, 5, 4), "abort");
        chk("abort.err_pulse", 32'(mem_bus_err), 0);
        access(1, 0, F3_B,  32'h100, 0, 32'h0000007F, 1, mk(32'h100, 0, 4'b0001, 0, 32'h0000007F, 0, 3, 2), "lb_pos");

        ID_memread = 1; ID_funct3 = F3_W; EX_result = 32'h120; data_mem_ready = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("midrst.req", 32'(data_mem_req), 0);
        chk("midrst.stall", 32'(mem_stall), 0);
        chk("midrst.read_data", data_mem_read_data, 0);
        chk("midrst.bus_err", 32'(mem_bus_err), 0);
        ID_memread = 0;
        @(posedge clk); #1 rst = 0;
        chk("midrst.idle_stall", 32'(mem_stall), 0);
        access(1, 0, F3_W, 32'h100, 0, 32'h11223344, 0, mk(32'h100, 0, 4'b1111, 0, 32'h11223344, 0, 2, 1), "post_rst");

        chk("scoreboard.empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
